// File: rtl/benes_cfg_sequencer.sv
// Benes config sequencer: streams stored switch selects into the interconnect.
// Macro BENES_CFG_HOLD_EN: hold last issued selects while idle (else zero).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_cfg_wren/waddr      config table write strobe / address
//   i_cfg_wmod/wslot      module-select / slot-select write data
//   i_start/i_base/i_len  run request, first entry, entry count
//   i_stall               freeze issue
//   o_module_select       module selects to the interconnect
//   o_slot_select         slot selects to the interconnect
//   o_cfg_valid           selects are a live entry this cycle
//   o_busy/o_done         run in progress / completion pulse

package FHE_ALU_PKG;
  localparam int STAGE_NUM  = 5;
  localparam int SWITCH_NUM = 4;
endpackage

module benes_cfg_sequencer #(
  parameter int STAGE_NUM   = FHE_ALU_PKG::STAGE_NUM,
  parameter int SWITCH_NUM  = FHE_ALU_PKG::SWITCH_NUM,
  parameter int CFG_DEPTH   = 64,
  parameter int NET_LATENCY = 12,
  localparam int AW = $clog2(CFG_DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_cfg_wren,
  input  logic [AW-1:0] i_cfg_waddr,
  input  logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] i_cfg_wmod,
  input  logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] i_cfg_wslot,
  input  logic i_start,
  input  logic [AW-1:0] i_base,
  input  logic [AW:0] i_len,
  input  logic i_stall,
  output logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] o_module_select,
  output logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] o_slot_select,
  output logic o_cfg_valid,
  output logic o_busy,
  output logic o_done
);

  localparam int SW = STAGE_NUM * SWITCH_NUM;
  localparam int EW = 2 * SW;
  localparam int DW = $clog2(NET_LATENCY + 1) + 1;

  typedef logic [EW-1:0] ent_t;
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic rd_v_q, rd_v_d;
  logic out_v_q, out_v_d;
  ent_t out_q, out_d;
  ent_t rd_q;
  ent_t sel;
  ent_t mem [CFG_DEPTH];

  logic start_ok;
  logic rd_fire;
  logic drain_tick;
  logic drain_end;

  assign start_ok = (state_q == S_IDLE) & i_start;
  assign rd_fire = (state_q == S_RUN) & ~i_stall;
  // Drain time is measured from the last valid, so hold the
  // count while an entry is still waiting to leave the pipe.
  assign drain_tick = ~(rd_v_q | (out_v_q & i_stall));
  assign drain_end = (state_q == S_DRAIN) & drain_tick
                   & (dcnt_q == '0);

  // Table storage is never reset; read port returns old data
  // on a same-address write.
  always_ff @(posedge clk) begin
    if (i_cfg_wren) begin
      mem[i_cfg_waddr] <= {i_cfg_wmod, i_cfg_wslot};
    end
    if (rd_fire) begin
      rd_q <= mem[addr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = (i_len == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (rd_fire && cnt_q == {{AW{1'b0}}, 1'b1}) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_end) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    rd_v_d  = rd_v_q;
    out_v_d = out_v_q;
    out_d   = out_q;
    if (start_ok) begin
      addr_d = i_base;
      cnt_d  = i_len;
      dcnt_d = DW'(NET_LATENCY);
    end
    if (rd_fire) begin
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q - 1'b1;
    end
    if (state_q == S_DRAIN && drain_tick
        && dcnt_q != '0) begin
      dcnt_d = dcnt_q - 1'b1;
    end
    if (!i_stall) begin
      rd_v_d  = rd_fire;
      out_v_d = rd_v_q;
      out_d   = rd_v_q ? rd_q : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      rd_v_q  <= 1'b0;
      out_v_q <= 1'b0;
      out_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      rd_v_q  <= rd_v_d;
      out_v_q <= out_v_d;
      out_q   <= out_d;
    end
  end

`ifdef BENES_CFG_HOLD_EN
  ent_t last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (o_cfg_valid) begin
      last_d = out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // A stalled entry stays in the output register but is not
  // presented, so it is issued exactly once when stall drops.
  always_comb begin
    o_busy = (state_q != S_IDLE);
    o_done = drain_end;
    o_cfg_valid = out_v_q & ~i_stall;
`ifdef BENES_CFG_HOLD_EN
    sel = o_cfg_valid ? out_q : last_q;
`else
    sel = o_cfg_valid ? out_q : '0;
`endif
    o_module_select = sel[EW-1:SW];
    o_slot_select = sel[SW-1:0];
  end

endmodule

// File: tb/tb_benes_cfg_sequencer.sv
// Scoreboard bench for benes_cfg_sequencer.
// Expected entries, done pulses and busy windows are queued by stimulus.

module tb_benes_cfg_sequencer;

  localparam int ST = FHE_ALU_PKG::STAGE_NUM;
  localparam int SWN = FHE_ALU_PKG::SWITCH_NUM;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam int LAT = 12;
  localparam int SW = ST * SWN;
  localparam int EW = 2 * SW;

  typedef logic [EW-1:0] ent_t;
  typedef struct {
    int   c;
    ent_t d;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_cfg_wren = 1'b0;
  logic [AW-1:0] i_cfg_waddr = '0;
  logic [ST-1:0][SWN-1:0] i_cfg_wmod = '0;
  logic [ST-1:0][SWN-1:0] i_cfg_wslot = '0;
  logic i_start = 1'b0;
  logic [AW-1:0] i_base = '0;
  logic [AW:0] i_len = '0;
  logic i_stall = 1'b0;
  logic [ST-1:0][SWN-1:0] o_module_select;
  logic [ST-1:0][SWN-1:0] o_slot_select;
  logic o_cfg_valid;
  logic o_busy;
  logic o_done;

  benes_cfg_sequencer #(
    .STAGE_NUM(ST),
    .SWITCH_NUM(SWN),
    .CFG_DEPTH(DEPTH),
    .NET_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_cfg_wren(i_cfg_wren),
    .i_cfg_waddr(i_cfg_waddr),
    .i_cfg_wmod(i_cfg_wmod),
    .i_cfg_wslot(i_cfg_wslot),
    .i_start(i_start),
    .i_base(i_base),
    .i_len(i_len),
    .i_stall(i_stall),
    .o_module_select(o_module_select),
    .o_slot_select(o_slot_select),
    .o_cfg_valid(o_cfg_valid),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ent_t tbl [DEPTH];
  ev_t exp_q[$];
  int dq[$];
  int busy_lo = 1;
  int busy_hi = 0;
  int n_cmp = 0;
  int n_bad = 0;
  ent_t last_exp = '0;

  function automatic ent_t mk(logic [SWN-1:0] m,
                              logic [SWN-1:0] s);
    return {{ST{m}}, {ST{s}}};
  endfunction

  task automatic wr(input int a, input ent_t d);
    i_cfg_wren = 1'b1;
    i_cfg_waddr = a[AW-1:0];
    {i_cfg_wmod, i_cfg_wslot} = d;
    @(posedge clk);
    #1;
    i_cfg_wren = 1'b0;
    tbl[a] = d;
  endtask

  task automatic start(input int base, input int len,
                       output int t);
    i_base = base[AW-1:0];
    i_len = len[AW:0];
    i_start = 1'b1;
    t = cyc + 1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic push(input int c, input ent_t d);
    ev_t e;
    e.c = c;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Plain run: valids at t+2.., done LAT cycles after the last
  // valid (or after DRAIN entry when len is zero).
  task automatic expect_plain(input int t, input int base,
                              input int len, output int dc);
    for (int j = 0; j < len; j++) begin
      push(t + 2 + j, tbl[(base + j) % DEPTH]);
    end
    dc = (len == 0) ? t + LAT : t + len + 1 + LAT;
    dq.push_back(dc);
    busy_lo = t;
    busy_hi = dc;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: one comparison stream for entries, done, busy and
  // idle select values.
  initial begin
    ent_t sel;
    ent_t idle_exp;
    ev_t e;
    int dc;
    logic exp_b;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      sel = {o_module_select, o_slot_select};
      if (!rst_n) begin
        last_exp = '0;
        n_cmp++;
        if (o_cfg_valid || o_busy || o_done || sel != '0) begin
          n_bad++;
          $display("FAIL reset_out t=%0t got v=%0b b=%0b d=%0b sel=%h want all 0",
                   $time, o_cfg_valid, o_busy, o_done, sel);
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
          e = exp_q.pop_front();
          n_cmp++;
          if (!o_cfg_valid || e.c != cyc || sel != e.d) begin
            n_bad++;
            $display("FAIL entry cyc=%0d got v=%0b sel=%h want cyc=%0d sel=%h",
                     cyc, o_cfg_valid, sel, e.c, e.d);
          end
          last_exp = e.d;
        end else if (o_cfg_valid) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_valid cyc=%0d got sel=%h want no valid",
                   cyc, sel);
        end else begin
`ifdef BENES_CFG_HOLD_EN
          idle_exp = last_exp;
`else
          idle_exp = '0;
`endif
          n_cmp++;
          if (sel != idle_exp) begin
            n_bad++;
            $display("FAIL idle_sel cyc=%0d got %h want %h",
                     cyc, sel, idle_exp);
          end
        end
        if (dq.size() > 0 && dq[0] <= cyc) begin
          dc = dq.pop_front();
          n_cmp++;
          if (!o_done || dc != cyc) begin
            n_bad++;
            $display("FAIL done cyc=%0d got done=%0b want pulse at cyc %0d",
                     cyc, o_done, dc);
          end
        end else if (o_done) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done cyc=%0d got 1 want 0", cyc);
        end
        exp_b = (cyc >= busy_lo) && (cyc <= busy_hi);
        n_cmp++;
        if (o_busy !== exp_b) begin
          n_bad++;
          $display("FAIL busy cyc=%0d got %0b want %0b",
                   cyc, o_busy, exp_b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int dc;
    ent_t old5;
    ent_t new5;
    ent_t new7;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      wr(i, mk(SWN'(i), SWN'(i >> 2) ^ SWN'(9)));
    end
    for (int i = 0; i < 4; i++) begin
      wr(i, mk(SWN'(i + 1), SWN'(i + 1)));
    end

    // Basic run: 1,2,3,4 at T+2..T+5, done at T+17
    start(0, 4, t);
    expect_plain(t, 0, 4, dc);
    wait_to(dc + 2);

    // Address wrap 62,63,0,1
    start(62, 4, t);
    expect_plain(t, 62, 4, dc);
    wait_to(dc + 2);

    // Three stall cycles after the 2nd valid
    start(8, 5, t);
    push(t + 2, tbl[8]);
    push(t + 3, tbl[9]);
    push(t + 7, tbl[10]);
    push(t + 8, tbl[11]);
    push(t + 9, tbl[12]);
    dq.push_back(t + 9 + LAT);
    busy_lo = t;
    busy_hi = t + 9 + LAT;
    wait_to(t + 4);
    i_stall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_stall = 1'b0;
    wait_to(t + 9 + LAT + 2);

    // Start during RUN is dropped; then a zero-length run
    start(20, 4, t);
    expect_plain(t, 20, 4, dc);
    wait_to(t + 2);
    i_base = 6'd30;
    i_len = 7'd3;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_to(dc + 4);
    start(0, 0, t);
    expect_plain(t, 0, 0, dc);
    wait_to(dc + 2);

    // Full-depth run issues every entry once
    start(17, DEPTH, t);
    expect_plain(t, 17, DEPTH, dc);
    wait_to(dc + 2);

    // Reset during the 3rd valid aborts the run
    start(0, 5, t);
    expect_plain(t, 0, 5, dc);
    wait_to(t + 4);
    #1;
    exp_q.delete();
    dq.delete();
    busy_hi = cyc;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    i_base = '0;
    i_len = 7'd2;
    i_start = 1'b1;
    @(negedge clk);
    #2;
    t = cyc + 1;
    expect_plain(t, 0, 2, dc);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_to(dc + 2);

    // Same-cycle write/read of entry 5 gives old data; a write
    // ahead of the read pointer is seen by the same run.
    old5 = tbl[5];
    new5 = mk(SWN'(4'hE), SWN'(4'h7));
    new7 = mk(SWN'(4'hC), SWN'(4'h3));
    start(5, 4, t);
    push(t + 2, old5);
    push(t + 3, tbl[6]);
    push(t + 4, new7);
    push(t + 5, tbl[8]);
    dq.push_back(t + 5 + LAT);
    busy_lo = t;
    busy_hi = t + 5 + LAT;
    wr(5, new5);
    wr(7, new7);
    wait_to(t + 5 + LAT + 2);
    start(5, 1, t);
    expect_plain(t, 5, 1, dc);
    wait_to(dc + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/benes_cfg_sequencer.md
BENES_CFG_SEQUENCER -- requirements
Module: benes_cfg_sequencer

Interface
REQ-001 SHALL have parameter STAGE_NUM, default FHE_ALU_PKG::STAGE_NUM: Benes stage count.
REQ-002 SHALL have parameter SWITCH_NUM, default FHE_ALU_PKG::SWITCH_NUM: switches per stage.
REQ-003 SHALL have parameter CFG_DEPTH, default 64, power of two: config table entries; AW = log2(CFG_DEPTH).
REQ-004 SHALL have parameter NET_LATENCY, default 12: cycles from select presentation to the routed data leaving the interconnect.
REQ-005 SHALL have port clk  in  1: single clock, all logic on the rising edge.
REQ-006 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-007 SHALL have port i_cfg_wren  in  1: config table write strobe.
REQ-008 SHALL have port i_cfg_waddr  in  AW: config table write address.
REQ-009 SHALL have ports i_cfg_wmod, i_cfg_wslot  in  [SWITCH_NUM-1:0] x STAGE_NUM each: module-select and slot-select write data.
REQ-010 SHALL have port i_start  in  1: run request.
REQ-011 SHALL have ports i_base  in  AW and i_len  in  AW+1: first entry and entry count.
REQ-012 SHALL have port i_stall  in  1: freeze request.
REQ-013 SHALL have ports o_module_select, o_slot_select  out  [SWITCH_NUM-1:0] x STAGE_NUM: drive the interconnect i_module_select / i_slot_select.
REQ-014 SHALL have port o_cfg_valid  out  1: selects on the outputs are a live entry this cycle.
REQ-015 SHALL have ports o_busy  out  1 and o_done  out  1: run in progress; one-cycle completion pulse.

Function
REQ-016 SHALL implement a CFG_DEPTH-entry table with one write port and one registered read port; a same-address read and write in one cycle SHALL return the old data.
REQ-017 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE; o_busy = 1 in RUN and DRAIN.
REQ-018 SHALL accept i_start only in IDLE; i_start in RUN/DRAIN SHALL be ignored and SHALL NOT be queued.
REQ-019 Start sampled at edge T with i_len = N > 0: o_cfg_valid SHALL be high from T+2 through T+1+N, with entries base, base+1, ... in order.
REQ-020 Read address SHALL wrap modulo CFG_DEPTH; i_len = CFG_DEPTH SHALL issue every entry exactly once.
REQ-021 i_len = 0 SHALL skip RUN, enter DRAIN, and issue no valid.
REQ-022 i_stall high SHALL freeze address, counters and output registers; o_cfg_valid SHALL be 0 during the stall cycle; issue SHALL resume without loss or duplication when i_stall drops.
REQ-023 DRAIN SHALL count NET_LATENCY cycles after the last valid, ignoring i_stall; o_done SHALL pulse on the final DRAIN cycle, then the FSM SHALL enter IDLE.
REQ-024 Table writes SHALL be permitted in every state; a write to an entry not yet read in the current run SHALL be visible to that run.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, all outputs 0 and counters 0; table contents SHALL NOT be reset.
REQ-026 Reset mid-RUN or mid-DRAIN SHALL abort the run with no o_done; after rst_n rises, the block SHALL accept i_start on the first clock edge.

Configuration
REQ-027 With BENES_CFG_HOLD_EN defined, o_module_select/o_slot_select SHALL hold the last issued entry while o_cfg_valid = 0.
REQ-028 Without BENES_CFG_HOLD_EN, o_module_select/o_slot_select SHALL be 0 whenever o_cfg_valid = 0.

Verification
REQ-029 Write entries 0..3 = 0x1,0x2,0x3,0x4 (all stages), start base=0 len=4 at T -> valid at T+2..T+5 with 1,2,3,4; o_done at T+5+12.
REQ-030 Start base=62 len=4 (CFG_DEPTH=64) -> entries 62,63,0,1 in order.
REQ-031 Stall for 3 cycles after the 2nd valid of a len=5 run -> 5 valids, none repeated, last valid delayed by exactly 3 cycles.
REQ-032 i_start pulsed during RUN; start with len=0 -> the first is ignored; the second gives no valid and o_done 12 cycles after DRAIN entry.
REQ-033 rst_n low at the 3rd valid -> outputs 0 asynchronously; no o_done; a new start accepted on the first edge after release.
REQ-034 Same-cycle write and read of entry 5 -> old value issued; run both macro settings and check output values while idle.
